// File: rtl/dm_abs_cmd.sv
// dm_abs_cmd: Debug Module abstract-command executor.
// Runs "Access Register" commands against the hart debug register port,
// owns the sticky cmderr code and the busy flag.
// Optional feature macro: DM_CMD_TIMEOUT_EN adds a core-response timeout
// (TIMEOUT_CYCLES) that aborts a stuck access with cmderr 3.
//
// Handshake: a request transfers on a cycle where dbg_req_valid and
// dbg_req_ready are both high; valid stays high and write/regno/wdata stay
// stable until that cycle. dbg_resp_valid is a single-cycle pulse with no
// back-pressure, accepted only while waiting for a response.
module dm_abs_cmd #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  sys_clk,
  input  logic                  sys_rstn,
  input  logic [DATA_WIDTH-1:0] command,
  input  logic                  cmd_update,
  input  logic [DATA_WIDTH-1:0] data0,
  output logic                  cmd_finished,
  output logic [DATA_WIDTH-1:0] cmd_read_data,
  output logic                  busy,
  output logic [2:0]            cmderr,
  input  logic                  cmderr_clr,
  input  logic                  hart_halted,
  output logic                  dbg_req_valid,
  input  logic                  dbg_req_ready,
  output logic                  dbg_req_write,
  output logic [15:0]           dbg_req_regno,
  output logic [DATA_WIDTH-1:0] dbg_req_wdata,
  input  logic                  dbg_resp_valid,
  input  logic [DATA_WIDTH-1:0] dbg_resp_rdata,
  output logic [1:0]            dbg_fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_BUSY      = 3'd1;
  localparam logic [2:0] ERR_NOTSUP    = 3'd2;
  localparam logic [2:0] ERR_EXCEPTION = 3'd3;
  localparam logic [2:0] ERR_HALTRESUME = 3'd4;

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [15:0]           regno_q, regno_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [2:0]            cmderr_q, cmderr_d;

  logic                  err_set;
  logic [2:0]            err_code;

  // Command word fields.
  logic [7:0]  cmd_type;
  logic [2:0]  cmd_aarsize;
  logic        cmd_postexec;
  logic        cmd_transfer;
  logic        cmd_write;
  logic [15:0] cmd_regno;
  logic        cmd_regno_ok;
  logic        cmd_supported;
  logic        unused_cmd_bits;

  assign cmd_type      = command[31:24];
  assign cmd_aarsize   = command[22:20];
  assign cmd_postexec  = command[18];
  assign cmd_transfer  = command[17];
  assign cmd_write     = command[16];
  assign cmd_regno     = command[15:0];
  assign unused_cmd_bits = ^{command[23], command[19]};

  // CSRs occupy 0x0000-0x0FFF, GPRs 0x1000-0x101F.
  assign cmd_regno_ok  = (cmd_regno[15:12] == 4'h0) ||
                         (cmd_regno[15:5] == 11'h080);
  assign cmd_supported = (cmd_type == 8'h00) && (cmd_aarsize == 3'd2) &&
                         !cmd_postexec && cmd_regno_ok;

`ifdef DM_CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-state, capture and error-event logic.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    regno_d  = regno_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_set  = 1'b0;
    err_code = ERR_NONE;
`ifdef DM_CMD_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif

    // A new command while one is in flight is dropped and flagged.
    if (cmd_update && (state_q != IDLE)) begin
      err_set  = 1'b1;
      err_code = ERR_BUSY;
    end

    case (state_q)
      IDLE: begin
        if (cmd_update) begin
          write_d = cmd_write;
          regno_d = cmd_regno;
          wdata_d = data0;
          rdata_d = '0;
`ifdef DM_CMD_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (!hart_halted) begin
            err_set  = 1'b1;
            err_code = ERR_HALTRESUME;
            state_d  = DONE;
          end else if (!cmd_supported) begin
            err_set  = 1'b1;
            err_code = ERR_NOTSUP;
            state_d  = DONE;
          end else if (!cmd_transfer) begin
            state_d  = DONE;
          end else begin
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        if (dbg_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (dbg_resp_valid) begin
          if (!write_q) begin
            rdata_d = dbg_resp_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef DM_CMD_TIMEOUT_EN
    // Abort an access the core never completes; a real response wins a tie.
    if ((state_q == REQ) || ((state_q == WAIT) && !dbg_resp_valid)) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d  = DONE;
        rdata_d  = '0;
        err_set  = 1'b1;
        err_code = ERR_EXCEPTION;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  // Sticky error: only the first error lands; an error beats a same-cycle clear.
  always_comb begin
    cmderr_d = cmderr_q;
    if (cmderr_clr) begin
      cmderr_d = ERR_NONE;
    end
    if (err_set && ((cmderr_q == ERR_NONE) || cmderr_clr)) begin
      cmderr_d = err_code;
    end
  end

  // State and captured-command registers.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      regno_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cmderr_q <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      regno_q  <= regno_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cmderr_q <= cmderr_d;
    end
  end

`ifdef DM_CMD_TIMEOUT_EN
  // Timeout counter register.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Outputs decode straight from flops so reset clears them immediately.
  assign busy          = (state_q != IDLE);
  assign cmd_finished  = (state_q == DONE);
  assign cmd_read_data = (state_q == DONE) ? rdata_q : '0;
  assign cmderr        = cmderr_q;
  assign dbg_req_valid = (state_q == REQ);
  assign dbg_req_write = ((state_q == REQ) || (state_q == WAIT)) && write_q;
  assign dbg_req_regno = ((state_q == REQ) || (state_q == WAIT)) ? regno_q : 16'h0;
  assign dbg_req_wdata = ((state_q == REQ) || (state_q == WAIT)) ? wdata_q : '0;
  assign dbg_fsm_state = state_q;

endmodule

// File: tb/tb_dm_abs_cmd.sv
// tb_dm_abs_cmd: scenario tasks plus randomized commands for dm_abs_cmd,
// checked against a rule-level model of the abstract-command behaviour.
module tb_dm_abs_cmd;

  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic          sys_clk = 1'b0;
  logic          sys_rstn;
  logic [DW-1:0] command;
  logic          cmd_update;
  logic [DW-1:0] data0;
  logic          cmd_finished;
  logic [DW-1:0] cmd_read_data;
  logic          busy;
  logic [2:0]    cmderr;
  logic          cmderr_clr;
  logic          hart_halted;
  logic          dbg_req_valid;
  logic          dbg_req_ready;
  logic          dbg_req_write;
  logic [15:0]   dbg_req_regno;
  logic [DW-1:0] dbg_req_wdata;
  logic          dbg_resp_valid;
  logic [DW-1:0] dbg_resp_rdata;
  logic [1:0]    dbg_fsm_state;

  always #5 sys_clk = ~sys_clk;

  dm_abs_cmd #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn),
    .command(command), .cmd_update(cmd_update), .data0(data0),
    .cmd_finished(cmd_finished), .cmd_read_data(cmd_read_data),
    .busy(busy), .cmderr(cmderr), .cmderr_clr(cmderr_clr),
    .hart_halted(hart_halted),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_write(dbg_req_write), .dbg_req_regno(dbg_req_regno),
    .dbg_req_wdata(dbg_req_wdata), .dbg_resp_valid(dbg_resp_valid),
    .dbg_resp_rdata(dbg_resp_rdata), .dbg_fsm_state(dbg_fsm_state)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [DW-1:0] exp_q[$];

  // Observations filled in by run_cmd.
  int            obs_lat;
  logic [DW-1:0] obs_rd;
  logic [2:0]    obs_err;
  bit            obs_saw_req;
  bit            obs_stable;
  logic          obs_write;
  logic [15:0]   obs_regno;
  logic [DW-1:0] obs_wdata;
  logic          obs_fin_after;
  logic          obs_busy_after;

  // ---------------- reference model ----------------
  function automatic logic [2:0] model_err(input logic [31:0] cmd, input logic halted);
    int  regno;
    bit  legal;
    regno = int'(cmd[15:0]);
    legal = (regno <= 'h0FFF) || ((regno >= 'h1000) && (regno <= 'h101F));
    if (!halted) return 3'd4;
    if ((cmd[31:24] != 8'd0) || (cmd[22:20] != 3'd2) || cmd[18] || !legal) return 3'd2;
    return 3'd0;
  endfunction

  function automatic bit model_access(input logic [31:0] cmd, input logic halted);
    return (model_err(cmd, halted) == 3'd0) && cmd[17];
  endfunction

  function automatic int model_lat(input logic [31:0] cmd, input logic halted,
                                   input int rw, input int sw);
    return model_access(cmd, halted) ? (3 + rw + sw) : 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_err();
    cmderr_clr = 1'b1;
    step();
    cmderr_clr = 1'b0;
  endtask

  // Issues one command and plays the core side: ready after ready_wait REQ
  // cycles, response after resp_wait WAIT cycles. Latency counts cycles from
  // the cmd_update cycle to the cmd_finished cycle.
  task automatic run_cmd(input logic [31:0] cmd, input logic [31:0] d0,
                         input logic halted, input int ready_wait,
                         input int resp_wait, input logic [31:0] rdata,
                         input bit inject_busy);
    int req_cnt;
    int wait_cnt;
    bit injected;
    req_cnt = 0; wait_cnt = 0; injected = 0;
    obs_lat = -1; obs_rd = '0; obs_err = cmderr; obs_saw_req = 0; obs_stable = 1;
    obs_write = 0; obs_regno = '0; obs_wdata = '0;
    command = cmd; data0 = d0; hart_halted = halted; cmd_update = 1'b1;
    step();
    cmd_update = 1'b0;
    command = $urandom();
    data0 = $urandom();
    for (int cyc = 1; cyc <= 200; cyc++) begin
      dbg_req_ready = 1'b0; dbg_resp_valid = 1'b0; dbg_resp_rdata = $urandom();
      cmd_update = 1'b0;
      if (cmd_finished) begin
        obs_lat = cyc; obs_rd = cmd_read_data; obs_err = cmderr;
        break;
      end
      if (dbg_req_valid) begin
        if (!obs_saw_req) begin
          obs_saw_req = 1; obs_write = dbg_req_write;
          obs_regno = dbg_req_regno; obs_wdata = dbg_req_wdata;
        end else if ((obs_write !== dbg_req_write) || (obs_regno !== dbg_req_regno) ||
                     (obs_wdata !== dbg_req_wdata)) begin
          obs_stable = 0;
        end
        dbg_req_ready = (req_cnt >= ready_wait);
        req_cnt++;
      end else if (busy) begin
        if (inject_busy && !injected) begin
          cmd_update = 1'b1; command = 32'h00221002; injected = 1;
        end
        if (wait_cnt >= resp_wait) begin
          dbg_resp_valid = 1'b1; dbg_resp_rdata = rdata;
        end
        wait_cnt++;
      end
      step();
    end
    dbg_req_ready = 1'b0; dbg_resp_valid = 1'b0; cmd_update = 1'b0;
    step();
    obs_fin_after = cmd_finished;
    obs_busy_after = busy;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    sys_rstn = 1'b0; command = '0; cmd_update = 0; data0 = '0; cmderr_clr = 0;
    hart_halted = 0; dbg_req_ready = 0; dbg_resp_valid = 0; dbg_resp_rdata = '0;
    #1;
    vec_cnt++;
    if ({cmd_finished, busy, dbg_req_valid, dbg_req_write} !== 4'b0) begin
      err_cnt++; $display("FAIL reset_flags: got %b expected 0000",
                          {cmd_finished, busy, dbg_req_valid, dbg_req_write});
    end
    vec_cnt++;
    if ({cmd_read_data, dbg_req_wdata, dbg_req_regno, cmderr} !== '0) begin
      err_cnt++; $display("FAIL reset_data: rd=%0h wdata=%0h regno=%0h cmderr=%0d expected all 0",
                          cmd_read_data, dbg_req_wdata, dbg_req_regno, cmderr);
    end
    step(); step();
    sys_rstn = 1'b1;
    step();
  endtask

  task automatic test_read_gpr();
    run_cmd(32'h00221001, 32'h0, 1'b1, 0, 0, 32'hDEADBEEF, 0);
    vec_cnt++;
    if (obs_regno !== 16'h1001 || obs_write !== 1'b0 || !obs_saw_req) begin
      err_cnt++; $display("FAIL read_req: regno=%0h write=%0b seen=%0d expected 1001/0/1",
                          obs_regno, obs_write, obs_saw_req);
    end
    vec_cnt++;
    if (obs_lat !== 3 || obs_rd !== 32'hDEADBEEF || obs_err !== 3'd0) begin
      err_cnt++; $display("FAIL read_done: lat=%0d rd=%0h err=%0d expected 3/deadbeef/0",
                          obs_lat, obs_rd, obs_err);
    end
    vec_cnt++;
    if (obs_fin_after !== 1'b0 || obs_busy_after !== 1'b0) begin
      err_cnt++; $display("FAIL read_pulse: fin_after=%0b busy_after=%0b expected 0/0",
                          obs_fin_after, obs_busy_after);
    end
  endtask

  task automatic test_write_csr();
    run_cmd(32'h002307B1, 32'h12345678, 1'b1, 0, 1, 32'hCAFEF00D, 0);
    vec_cnt++;
    if (obs_wdata !== 32'h12345678 || obs_write !== 1'b1 || obs_regno !== 16'h07B1) begin
      err_cnt++; $display("FAIL write_req: wdata=%0h write=%0b regno=%0h expected 12345678/1/7b1",
                          obs_wdata, obs_write, obs_regno);
    end
    vec_cnt++;
    if (obs_lat !== 4 || obs_rd !== 32'h0 || obs_err !== 3'd0) begin
      err_cnt++; $display("FAIL write_done: lat=%0d rd=%0h err=%0d expected 4/0/0",
                          obs_lat, obs_rd, obs_err);
    end
  endtask

  task automatic test_errors();
    run_cmd(32'h00221001, 32'h0, 1'b0, 0, 0, 32'h1, 0);
    vec_cnt++;
    if (obs_lat !== 1 || obs_err !== 3'd4 || obs_saw_req || obs_rd !== 32'h0) begin
      err_cnt++; $display("FAIL not_halted: lat=%0d err=%0d req=%0d rd=%0h expected 1/4/0/0",
                          obs_lat, obs_err, obs_saw_req, obs_rd);
    end
    // First error sticks: a following unsupported command keeps code 4.
    run_cmd(32'h00321001, 32'h0, 1'b1, 0, 0, 32'h1, 0);
    vec_cnt++;
    if (obs_err !== 3'd4) begin
      err_cnt++; $display("FAIL sticky: got %0d expected 4", obs_err);
    end
    clear_err();
    run_cmd(32'h00321001, 32'h0, 1'b1, 0, 0, 32'h1, 0);
    vec_cnt++;
    if (obs_lat !== 1 || obs_err !== 3'd2 || obs_saw_req) begin
      err_cnt++; $display("FAIL aarsize3: lat=%0d err=%0d req=%0d expected 1/2/0",
                          obs_lat, obs_err, obs_saw_req);
    end
    clear_err();
    // Boundary register numbers: 0x101F legal, 0x1020 not.
    run_cmd(32'h00221020, 32'h0, 1'b1, 0, 0, 32'h1, 0);
    vec_cnt++;
    if (obs_err !== 3'd2 || obs_saw_req) begin
      err_cnt++; $display("FAIL regno_1020: err=%0d req=%0d expected 2/0", obs_err, obs_saw_req);
    end
    clear_err();
    run_cmd(32'h0022101F, 32'h0, 1'b1, 0, 0, 32'h55AA55AA, 0);
    vec_cnt++;
    if (obs_err !== 3'd0 || obs_rd !== 32'h55AA55AA || obs_regno !== 16'h101F) begin
      err_cnt++; $display("FAIL regno_101f: err=%0d rd=%0h regno=%0h expected 0/55aa55aa/101f",
                          obs_err, obs_rd, obs_regno);
    end
    // transfer=0: finishes next cycle, no access, no error.
    run_cmd(32'h00201001, 32'h0, 1'b1, 0, 0, 32'h1, 0);
    vec_cnt++;
    if (obs_lat !== 1 || obs_err !== 3'd0 || obs_saw_req) begin
      err_cnt++; $display("FAIL no_transfer: lat=%0d err=%0d req=%0d expected 1/0/0",
                          obs_lat, obs_err, obs_saw_req);
    end
  endtask

  task automatic test_busy();
    run_cmd(32'h00221005, 32'h0, 1'b1, 0, 2, 32'h0BADF00D, 1);
    vec_cnt++;
    if (obs_err !== 3'd1 || obs_rd !== 32'h0BADF00D || obs_lat !== 5 || obs_regno !== 16'h1005) begin
      err_cnt++; $display("FAIL busy: err=%0d rd=%0h lat=%0d regno=%0h expected 1/badf00d/5/1005",
                          obs_err, obs_rd, obs_lat, obs_regno);
    end
    clear_err();
    vec_cnt++;
    if (cmderr !== 3'd0) begin
      err_cnt++; $display("FAIL cmderr_clr: got %0d expected 0", cmderr);
    end
  endtask

  task automatic test_ready_stall();
    run_cmd(32'h00231008, 32'hA5A5F00F, 1'b1, 5, 0, 32'h0, 0);
    vec_cnt++;
    if (!obs_stable || obs_wdata !== 32'hA5A5F00F || obs_regno !== 16'h1008) begin
      err_cnt++; $display("FAIL stall_fields: stable=%0d wdata=%0h regno=%0h expected 1/a5a5f00f/1008",
                          obs_stable, obs_wdata, obs_regno);
    end
    vec_cnt++;
    if (obs_lat !== 8 || obs_err !== 3'd0) begin
      err_cnt++; $display("FAIL stall_done: lat=%0d err=%0d expected 8/0", obs_lat, obs_err);
    end
  endtask

  task automatic test_reset_mid();
    bit fin_seen;
    fin_seen = 0;
    command = 32'h00221003; hart_halted = 1; cmd_update = 1;
    step();
    cmd_update = 0; dbg_req_ready = 1;
    step();
    dbg_req_ready = 0;
    sys_rstn = 1'b0;
    #1;
    vec_cnt++;
    if ({busy, cmd_finished, dbg_req_valid} !== 3'b0 || dbg_req_regno !== 16'h0) begin
      err_cnt++; $display("FAIL reset_mid: busy=%0b fin=%0b valid=%0b regno=%0h expected 0/0/0/0",
                          busy, cmd_finished, dbg_req_valid, dbg_req_regno);
    end
    step();
    sys_rstn = 1'b1;
    dbg_resp_valid = 1; dbg_resp_rdata = 32'h77777777;
    for (int i = 0; i < 4; i++) begin
      step();
      dbg_resp_valid = 0;
      if (cmd_finished) fin_seen = 1;
    end
    vec_cnt++;
    if (fin_seen) begin
      err_cnt++; $display("FAIL reset_no_finish: got finish=1 expected 0");
    end
    run_cmd(32'h00221004, 32'h0, 1'b1, 1, 1, 32'h13572468, 0);
    vec_cnt++;
    if (obs_lat !== 5 || obs_rd !== 32'h13572468 || obs_err !== 3'd0) begin
      err_cnt++; $display("FAIL after_reset: lat=%0d rd=%0h err=%0d expected 5/13572468/0",
                          obs_lat, obs_rd, obs_err);
    end
  endtask

  task automatic test_random();
    logic [31:0] cmd, d0, rdata;
    logic        halted;
    int          rw, sw, sel;
    for (int n = 0; n < 40; n++) begin
      cmd = '0;
      cmd[31:24] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      cmd[22:20] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      cmd[18]    = ($urandom_range(0, 7) == 0);
      cmd[17]    = ($urandom_range(0, 5) != 0);
      cmd[16]    = $urandom_range(0, 1);
      cmd[23]    = $urandom_range(0, 1);
      cmd[19]    = $urandom_range(0, 1);
      sel = $urandom_range(0, 4);
      cmd[15:0]  = (sel == 0) ? 16'($urandom_range(16'h1020, 16'hFFFF)) :
                   (sel <= 2) ? 16'($urandom_range(16'h1000, 16'h101F)) :
                                16'($urandom_range(0, 16'h0FFF));
      halted = ($urandom_range(0, 7) != 0);
      d0 = $urandom(); rdata = $urandom();
      rw = $urandom_range(0, 3); sw = $urandom_range(0, 3);
      exp_q.push_back((model_access(cmd, halted) && !cmd[16]) ? rdata : 32'h0);
      clear_err();
      run_cmd(cmd, d0, halted, rw, sw, rdata, 0);
      vec_cnt++;
      if (obs_rd !== exp_q[0] || obs_err !== model_err(cmd, halted) ||
          obs_lat !== model_lat(cmd, halted, rw, sw) ||
          obs_saw_req !== model_access(cmd, halted)) begin
        err_cnt++; $display("FAIL rand_%0d cmd=%0h: rd=%0h err=%0d lat=%0d req=%0d expected %0h/%0d/%0d/%0d",
                            n, cmd, obs_rd, obs_err, obs_lat, obs_saw_req, exp_q[0],
                            model_err(cmd, halted), model_lat(cmd, halted, rw, sw),
                            model_access(cmd, halted));
      end
      void'(exp_q.pop_front());
      if (model_access(cmd, halted)) begin
        vec_cnt++;
        if (obs_write !== cmd[16] || obs_regno !== cmd[15:0] || obs_wdata !== d0 || !obs_stable) begin
          err_cnt++; $display("FAIL rand_req_%0d: write=%0b regno=%0h wdata=%0h stable=%0d expected %0b/%0h/%0h/1",
                              n, obs_write, obs_regno, obs_wdata, obs_stable, cmd[16], cmd[15:0], d0);
        end
      end
    end
  endtask

`ifdef DM_CMD_TIMEOUT_EN
  task automatic test_timeout();
    clear_err();
    run_cmd(32'h00221001, 32'h0, 1'b1, 0, 1000, 32'hFFFFFFFF, 0);
    vec_cnt++;
    if (obs_lat !== 17 || obs_err !== 3'd3 || obs_rd !== 32'h0) begin
      err_cnt++; $display("FAIL timeout: lat=%0d err=%0d rd=%0h expected 17/3/0",
                          obs_lat, obs_err, obs_rd);
    end
    clear_err();
  endtask
`endif

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_gpr();
    test_write_csr();
    test_errors();
    test_busy();
    test_ready_stall();
    test_reset_mid();
`ifdef DM_CMD_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
